// File: rtl/perceptron_operand_packer_if.sv
// Bus bundle between the perceptron operand packer, its operand source,
// the combinational adder tree and the result consumer.
interface perceptron_operand_packer_if #(
  parameter int N_OPS = 12,
  parameter int OP_W  = 3,
  parameter int RES_W = 7
);
  // Both streams use valid/ready: a transfer happens on a rising clk edge
  // where valid and ready are both high; the offering side keeps data stable
  // while valid is high and ready is low.
  logic                   in_valid;
  logic                   in_ready;
  logic [OP_W-1:0]        in_data;
  logic                   in_last;
  logic [N_OPS*OP_W-1:0]  op;
  logic [RES_W-1:0]       res_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [RES_W-1:0]       out_res;
  logic                   out_fire;
  logic [3:0]             count;
  logic                   err;
  logic [1:0]             state_dbg;

  // Environment side: operand source, adder tree and result consumer.
  modport master (
    output in_valid, in_data, in_last, res_in, out_ready,
    input  in_ready, op, out_valid, out_res, out_fire, count, err, state_dbg
  );

  // Packer side.
  modport slave (
    input  in_valid, in_data, in_last, res_in, out_ready,
    output in_ready, op, out_valid, out_res, out_fire, count, err, state_dbg
  );
endinterface

// File: rtl/perceptron_operand_packer.sv
// Packs up to 12 streamed 3-bit operands onto the adder-tree bus and returns
// the tree's result. Define PERCEPTRON_PACKER_CHECK_EN for the sum checker.
module perceptron_operand_packer #(
  parameter int N_OPS = 12,
  parameter int OP_W  = 3,
  parameter int RES_W = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  perceptron_operand_packer_if.slave    bus
);
  typedef enum logic [1:0] {
    FILL = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [N_OPS*OP_W-1:0] op_q, op_d;
  logic [3:0]            count_q, count_d;
  logic                  out_valid_q, out_valid_d;
  logic [RES_W-1:0]      out_res_q, out_res_d;
  logic                  out_fire_q, out_fire_d;

`ifdef PERCEPTRON_PACKER_CHECK_EN
  logic [RES_W-1:0]      acc_q, acc_d;
  logic                  err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    out_fire_d  = out_fire_q;
`ifdef PERCEPTRON_PACKER_CHECK_EN
    acc_d       = acc_q;
    err_d       = err_q;
`endif
    case (state_q)
      FILL: begin
        if (bus.in_valid) begin
          for (int k = 0; k < N_OPS; k++) begin
            if (count_q == 4'(k)) op_d[k*OP_W +: OP_W] = bus.in_data;
          end
          count_d = count_q + 4'd1;
`ifdef PERCEPTRON_PACKER_CHECK_EN
          acc_d = acc_q + RES_W'(bus.in_data);
`endif
          if (count_q == 4'(N_OPS-1) || bus.in_last) state_d = EVAL;
        end
      end
      EVAL: begin
        out_res_d   = bus.res_in;
        out_fire_d  = bus.res_in[RES_W-1];
        out_valid_d = 1'b1;
        state_d     = HOLD;
`ifdef PERCEPTRON_PACKER_CHECK_EN
        // Independent threshold from the accumulated operands, versus the tree.
        if (bus.res_in[RES_W-1] != (acc_q >= RES_W'(64))) err_d = 1'b1;
`endif
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          op_d        = '0;
          count_d     = 4'd0;
          state_d     = FILL;
`ifdef PERCEPTRON_PACKER_CHECK_EN
          acc_d       = '0;
`endif
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      op_q        <= '0;
      count_q     <= 4'd0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_fire_q  <= 1'b0;
`ifdef PERCEPTRON_PACKER_CHECK_EN
      acc_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_fire_q  <= out_fire_d;
`ifdef PERCEPTRON_PACKER_CHECK_EN
      acc_q       <= acc_d;
      err_q       <= err_d;
`endif
    end
  end

  // in_ready is decoded from state alone so it never combinationally
  // depends on in_valid or out_ready.
  assign bus.in_ready  = (state_q == FILL);
  assign bus.op        = op_q;
  assign bus.count     = count_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;
  assign bus.out_fire  = out_fire_q;
  assign bus.state_dbg = state_q;
`ifdef PERCEPTRON_PACKER_CHECK_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_perceptron_operand_packer.sv
// Directed bench for perceptron_operand_packer with a behavioural adder tree
// that can be made to return a wrong threshold bit.
module tb_perceptron_operand_packer;
  logic clk;
  logic reset;
  logic force_bad;
  logic [6:0] tree_sum;
  logic [6:0] exp_q[$];
  logic [2:0] vec [12];
  logic       exp_err;
  int tests_run;
  int tests_failed;

  perceptron_operand_packer_if bus ();

  perceptron_operand_packer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural adder tree; optionally clears the threshold bit.
  always_comb begin
    tree_sum = 7'd0;
    for (int k = 0; k < 12; k++) tree_sum = tree_sum + 7'(bus.op[k*3 +: 3]);
  end
  assign bus.res_in = force_bad ? {1'b0, tree_sum[5:0]} : tree_sum;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // Streams vec[0..n-1] back to back, then checks EVAL, HOLD and the handshake.
  task automatic run_vector(input string tag, input int n, input logic [35:0] exp_op,
                            input logic [6:0] exp_res);
    logic [6:0] exp_r;
    exp_q.push_back(exp_res);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = vec[i];
      bus.in_last  = (n < 12) && (i == n - 1);
      check_eq({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check_eq({tag, "_eval_count"}, 64'(bus.count), 64'(n));
    check_eq({tag, "_eval_op"}, 64'(bus.op), 64'(exp_op));
    check_eq({tag, "_eval_ready"}, 64'(bus.in_ready), 64'd0);
    check_eq({tag, "_eval_valid"}, 64'(bus.out_valid), 64'd0);
    tick();
    check_eq({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    exp_r = exp_q.pop_front();
    check_eq({tag, "_out_res"}, 64'(bus.out_res), 64'(exp_r));
    check_eq({tag, "_out_fire"}, 64'(bus.out_fire), 64'(exp_r[6]));
    check_eq({tag, "_err"}, 64'(bus.err), 64'(exp_err));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq({tag, "_post_valid"}, 64'(bus.out_valid), 64'd0);
    check_eq({tag, "_post_count"}, 64'(bus.count), 64'd0);
    check_eq({tag, "_post_op"}, 64'(bus.op), 64'd0);
    check_eq({tag, "_post_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic fill_const(input logic [2:0] v);
    for (int i = 0; i < 12; i++) vec[i] = v;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    exp_err        = 1'b0;
    force_bad      = 1'b0;
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = 3'd0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_count", 64'(bus.count), 64'd0);
    check_eq("rst_op", 64'(bus.op), 64'd0);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_out_res", 64'(bus.out_res), 64'd0);
    check_eq("rst_out_fire", 64'(bus.out_fire), 64'd0);
    check_eq("rst_err", 64'(bus.err), 64'd0);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    tick();

    fill_const(3'd7);
    run_vector("all7", 12, 36'hFFFFFFFFF, 7'd84);
    fill_const(3'd5);
    run_vector("all5", 12, 36'hB6DB6DB6D, 7'd60);
    vec[11] = 3'd7;
    run_vector("five7", 12, 36'hF6DB6DB6D, 7'd62);
    fill_const(3'd7);
    run_vector("short3", 3, 36'h0000001FF, 7'd21);
    vec[0] = 3'd6;
    run_vector("single", 1, 36'h000000006, 7'd6);

    // Back-pressure: consumer stalls while extra beats are offered.
    for (int i = 0; i < 12; i++) vec[i] = 3'(i % 8);
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = vec[i];
      tick();
    end
    bus.in_data = 3'd7;
    tick();
    for (int c = 0; c < 5; c++) begin
      check_eq("hold_valid", 64'(bus.out_valid), 64'd1);
      check_eq("hold_res", 64'(bus.out_res), 64'd34);
      check_eq("hold_fire", 64'(bus.out_fire), 64'd0);
      check_eq("hold_op", 64'(bus.op), 64'h688FAC688);
      check_eq("hold_ready", 64'(bus.in_ready), 64'd0);
      check_eq("hold_count", 64'(bus.count), 64'd12);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq("hold_post_valid", 64'(bus.out_valid), 64'd0);
    check_eq("hold_post_op", 64'(bus.op), 64'd0);

    // Reset in the middle of a vector.
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 3'd7;
      tick();
    end
    bus.in_valid = 1'b0;
    check_eq("mid_count", 64'(bus.count), 64'd6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst_count", 64'(bus.count), 64'd0);
    check_eq("midrst_op", 64'(bus.op), 64'd0);
    check_eq("midrst_ready", 64'(bus.in_ready), 64'd1);
    fill_const(3'd7);
    run_vector("after_rst", 12, 36'hFFFFFFFFF, 7'd84);

    // Faulty tree: threshold bit forced low.
    force_bad = 1'b1;
    run_vector("bad_tree", 12, 36'hFFFFFFFFF, 7'd20);
    force_bad = 1'b0;
`ifdef PERCEPTRON_PACKER_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    check_eq("bad_err", 64'(bus.err), 64'(exp_err));
    run_vector("good_after_bad", 12, 36'hFFFFFFFFF, 7'd84);
    fill_const(3'd5);
    run_vector("good_after_bad5", 12, 36'hB6DB6DB6D, 7'd60);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_err = 1'b0;
    check_eq("err_cleared", 64'(bus.err), 64'd0);

    check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
